// File: rtl/rr_grant_indexer.sv
// Round-robin arbiter over 2**n requesters. It produces a registered grant index and a valid flag
// that drive an n-to-2**n decoder. A grant is held until done, or until MAX_HOLD cycles have passed.
module rr_grant_indexer #(
  parameter int n        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2**n-1:0] req,
  input  logic          done,
  output logic [n-1:0]  grant_idx,
  output logic          grant_valid,
  output logic          timeout
);

  localparam int          N     = 2**n;
  localparam logic [15:0] LIMIT = 16'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state, state_nx;
  logic [n-1:0] ptr, ptr_nx, idx_nx, sel, cand;
  logic [15:0] cnt, cnt_nx;
  logic        timeout_nx, found;

  // Find the first set request at or after ptr. The n-bit add wraps the search past the top requester.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + n'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = grant_idx;
    ptr_nx     = ptr;
    cnt_nx     = cnt;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          idx_nx   = sel;
          cnt_nx   = '0;
        end
      end
      GRANT: begin
        // done wins over the hold limit, so a release in the limit cycle does not raise timeout
        if (done || cnt == LIMIT) begin
          state_nx   = IDLE;
          ptr_nx     = grant_idx + n'(1);
          cnt_nx     = '0;
          timeout_nx = !done;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      ptr       <= '0;
      cnt       <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      grant_idx <= idx_nx;
      ptr       <= ptr_nx;
      cnt       <= cnt_nx;
      timeout   <= timeout_nx;
    end
  end

  assign grant_valid = (state == GRANT);

endmodule

// File: doc/rr_grant_indexer.md
Name: rr_grant_indexer

Overview:
- Round-robin arbiter over 2**n requesters. Outputs a registered binary grant index plus a grant-valid qualifier.
- Sits directly upstream of the generic n-to-2**n decoder: grant_idx drives the decoder's w input and grant_valid drives its en input. The decoder output is then the one-hot grant vector.
- Grants are held until the owner signals done, or until a hold-time limit expires.

Parameters:
- n, 4, index width; number of requesters is 2**n.
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; legal range 1 to 2**16-1.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  2**n  request vector, bit i = requester i wants a grant; level-sensitive.
- done  input  1  current owner releases the grant; sampled only in GRANT state.
- grant_idx  output  n  registered index of the current owner.
- grant_valid  output  1  registered; high while a grant is held. Feeds the decoder enable.
- timeout  output  1  registered one-cycle pulse when a grant is force-released by the MAX_HOLD limit.

Behaviour:
- Reset (rst high at a rising edge): state=IDLE, grant_idx=0, grant_valid=0, timeout=0, priority pointer ptr=0, hold counter=0.
  - Reset mid-grant drops grant_valid on that same edge. No completion of the in-flight grant.
- State IDLE:
  - grant_valid=0.
  - If req is nonzero: select the first set bit at or after ptr, searching upward with wrap from 2**n-1 to 0.
  - The selected index is registered into grant_idx; grant_valid=1 and state=GRANT on the next edge.
  - Latency: req seen at edge k gives grant_valid high after edge k.
  - If req is zero: stay in IDLE; grant_idx holds its last value.
- State GRANT:
  - grant_idx and grant_valid are stable; req changes are ignored, including the owner dropping its req.
  - Hold counter increments by 1 per cycle in GRANT; it is 0 in the first GRANT cycle.
  - done=1: next edge goes to IDLE, grant_valid=0, ptr=grant_idx+1 modulo 2**n, counter=0, timeout=0.
  - Counter reaches MAX_HOLD-1 with done=0: same transition as done, but timeout=1 for exactly one cycle.
  - done=1 in the limit cycle: treated as a normal release, timeout=0 (done has priority).
- Gap between consecutive grants: at least one IDLE cycle with grant_valid=0. The downstream decoder therefore outputs all-zero for at least one cycle between owners.
- Fairness: after owner i releases, requester i has lowest priority. With all requesters continuously asserting, grants rotate i, i+1, … with wrap.
- grant_idx changes only on the IDLE-to-GRANT transition; it is never X after reset.
- done and timeout are ignored or cleared in IDLE; done in IDLE has no effect.
- Pointer arithmetic is n bits wide with natural wrap: 2**n-1 + 1 gives 0.

Test Plan:
- Reset check: n=2, drive rst=1 for 2 cycles with req=4'b1111 → grant_valid=0, grant_idx=0, timeout=0 throughout reset.
  - First edge after release: grant_valid=1, grant_idx=0.
- Rotation: n=2, req=4'b1111 held, done pulsed one cycle after each grant → grant_idx sequence 0,1,2,3,0.
  - grant_valid low for exactly one cycle between grants.
- Sparse wrap: n=2, ptr=3 after owner 2 releases, req=4'b0011 → grant_idx=0 (wrap past 3). After release, req=4'b0011 → grant_idx=1.
- Timeout: MAX_HOLD=4, req=4'b0100, done never asserted → grant_valid high for 4 cycles.
  - Then a timeout pulse of 1 cycle, grant_valid=0, next grant_idx=2 again after one IDLE cycle.
- Done vs limit collision: MAX_HOLD=4, done=1 in the 4th GRANT cycle → release with timeout=0.
- Owner drops req plus mid-grant reset: owner 1 drops req in GRANT → grant stays with idx=1 until done.
  - Assert rst in the 2nd GRANT cycle → grant_valid=0 next edge, ptr=0, and the next grant with req=4'b0110 is idx=1.
